// File: rtl/letc_core_pkg.sv
// Shared LETC core pipeline types: memory-op encodings and the E1->E2->W stage bundles.
package letc_core_pkg;

  typedef enum logic [1:0] {
    MEM_OP_NOP   = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2
  } memory_op_e;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'd0,
    SIZE_HALFWORD = 2'd1,
    SIZE_WORD     = 2'd2
  } memory_size_e;

  typedef struct packed {
    logic         valid;
    logic [1:0]   rd_src;
    logic [4:0]   rd_idx;
    logic         rd_we;
    logic [2:0]   csr_op;
    logic [11:0]  csr_idx;
    logic [31:0]  old_csr_value;
    logic [31:0]  alu_result;
    logic [31:0]  rs2;
    memory_op_e   memory_op;
    memory_size_e memory_size;
    logic         memory_signed;
  } e1_to_e2_s;

  typedef struct packed {
    logic         valid;
    logic [1:0]   rd_src;
    logic [4:0]   rd_idx;
    logic         rd_we;
    logic [2:0]   csr_op;
    logic [11:0]  csr_idx;
    logic [31:0]  old_csr_value;
    logic [31:0]  alu_result;
    logic [31:0]  memory_rdata;
  } e2_to_w_s;

endpackage

// File: rtl/letc_core_stage_e2.sv
// LETC core E2 (memory) stage: issues one data-memory access at a time, aligns and
// extends load data, and registers the writeback bundle.
module letc_core_stage_e2
  import letc_core_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  e1_to_e2_s   i_e1_to_e2,
  input  logic        i_stage_stall,
  input  logic        i_stage_flush,
  output logic        o_stage_busy,
  output e2_to_w_s    o_e2_to_w,
  output logic        o_misaligned,
  output logic        o_dmem_req_valid,
  input  logic        i_dmem_req_ready,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_wen,
  output logic [3:0]  o_dmem_wstrb,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_rsp_valid,
  input  logic [31:0] i_dmem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_e;

  state_e      state_reg, state_next;
  e2_to_w_s    e2_to_w_reg, e2_to_w_next;
  logic [31:0] hold_rdata_reg;

  logic        mem_op;
  logic        misaligned;
  logic [1:0]  offset;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [3:0]  strb;
  logic [31:0] store_data;

  assign mem_op  = i_e1_to_e2.valid && (i_e1_to_e2.memory_op != MEM_OP_NOP);
  assign offset  = i_e1_to_e2.alu_result[1:0];
  assign shifted = i_dmem_rdata >> {offset, 3'b000};

  always_comb begin
    misaligned = 1'b0;
    strb       = 4'hF;
    load_data  = shifted;
    case (i_e1_to_e2.memory_size)
      SIZE_BYTE: begin
        strb      = 4'b0001 << offset;
        load_data = {{24{i_e1_to_e2.memory_signed & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALFWORD: begin
        misaligned = offset[0];
        strb       = 4'b0011 << offset;
        load_data  = {{16{i_e1_to_e2.memory_signed & shifted[15]}}, shifted[15:0]};
      end
      default: misaligned = (offset != 2'b00);
    endcase
    if (i_e1_to_e2.memory_op != MEM_OP_LOAD)
      load_data = '0;
  end

  // Each byte lane carries the replicated byte/halfword so memory can pick by strobe.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign store_data[gi*8 +: 8] =
      (i_e1_to_e2.memory_size == SIZE_BYTE)     ? i_e1_to_e2.rs2[7:0] :
      (i_e1_to_e2.memory_size == SIZE_HALFWORD) ? i_e1_to_e2.rs2[(gi % 2)*8 +: 8] :
                                                  i_e1_to_e2.rs2[gi*8 +: 8];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg      <= IDLE;
      e2_to_w_reg    <= '0;
      hold_rdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      e2_to_w_reg <= e2_to_w_next;
      if (state_reg == WAIT && i_dmem_rsp_valid && i_stage_stall && !i_stage_flush)
        hold_rdata_reg <= load_data;
    end
  end

  always_comb begin
    state_next       = state_reg;
    o_dmem_req_valid = 1'b0;
    o_stage_busy     = 1'b0;
    o_misaligned     = 1'b0;
    o_dmem_addr      = '0;
    o_dmem_wen       = 1'b0;
    o_dmem_wstrb     = '0;
    o_dmem_wdata     = '0;
    case (state_reg)
      IDLE: begin
        o_misaligned = mem_op && misaligned && !i_stage_stall && !i_stage_flush;
        if (mem_op && !misaligned) begin
          o_dmem_addr      = {i_e1_to_e2.alu_result[31:2], 2'b00};
          o_dmem_wen       = (i_e1_to_e2.memory_op == MEM_OP_STORE);
          o_dmem_wstrb     = strb;
          o_dmem_wdata     = store_data;
          o_dmem_req_valid = !i_stage_stall && !i_stage_flush;
          o_stage_busy     = !i_stage_flush;
          if (o_dmem_req_valid && i_dmem_req_ready)
            state_next = WAIT;
        end
      end
      WAIT: begin
        o_stage_busy = !(i_dmem_rsp_valid && (!i_stage_stall || i_stage_flush));
        if (i_stage_flush)
          state_next = i_dmem_rsp_valid ? IDLE : DRAIN;
        else if (i_dmem_rsp_valid)
          state_next = i_stage_stall ? DONE : IDLE;
      end
      DONE: begin
        o_stage_busy = i_stage_stall && !i_stage_flush;
        if (i_stage_flush || !i_stage_stall)
          state_next = IDLE;
      end
      DRAIN: begin
        o_stage_busy = 1'b1;
        if (i_dmem_rsp_valid)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    e2_to_w_next = e2_to_w_reg;
    if (i_stage_flush) begin
      e2_to_w_next.valid = 1'b0;
    end else if (!i_stage_stall) begin
      e2_to_w_next.valid = 1'b0;
      // Misaligned ops still carry their fields to W, but never as a valid instruction.
      if ((state_reg == IDLE && i_e1_to_e2.valid && (!mem_op || misaligned)) ||
          (state_reg == WAIT && i_dmem_rsp_valid) || state_reg == DONE) begin
        e2_to_w_next.valid         = !(state_reg == IDLE && mem_op);
        e2_to_w_next.rd_src        = i_e1_to_e2.rd_src;
        e2_to_w_next.rd_idx        = i_e1_to_e2.rd_idx;
        e2_to_w_next.rd_we         = i_e1_to_e2.rd_we;
        e2_to_w_next.csr_op        = i_e1_to_e2.csr_op;
        e2_to_w_next.csr_idx       = i_e1_to_e2.csr_idx;
        e2_to_w_next.old_csr_value = i_e1_to_e2.old_csr_value;
        e2_to_w_next.alu_result    = i_e1_to_e2.alu_result;
        e2_to_w_next.memory_rdata  = (state_reg == DONE) ? hold_rdata_reg :
                                     (state_reg == WAIT) ? load_data : 32'd0;
      end
    end
  end

  assign o_e2_to_w = e2_to_w_reg;

  rsp_only_when_outstanding: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_dmem_rsp_valid && (state_reg == IDLE || state_reg == DONE)));

endmodule

// File: tb/tb_letc_core_stage_e2.sv
// Directed bench for the LETC E2 stage: bypass, loads, stores, stall, flush, misalignment, reset.
module tb_letc_core_stage_e2;
  import letc_core_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  e1_to_e2_s   i_e1_to_e2;
  logic        i_stage_stall, i_stage_flush;
  logic        o_stage_busy;
  e2_to_w_s    o_e2_to_w;
  logic        o_misaligned;
  logic        o_dmem_req_valid;
  logic        i_dmem_req_ready;
  logic [31:0] o_dmem_addr;
  logic        o_dmem_wen;
  logic [3:0]  o_dmem_wstrb;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_rsp_valid;
  logic [31:0] i_dmem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  letc_core_stage_e2 dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_e1_to_e2       (i_e1_to_e2),
    .i_stage_stall    (i_stage_stall),
    .i_stage_flush    (i_stage_flush),
    .o_stage_busy     (o_stage_busy),
    .o_e2_to_w        (o_e2_to_w),
    .o_misaligned     (o_misaligned),
    .o_dmem_req_valid (o_dmem_req_valid),
    .i_dmem_req_ready (i_dmem_req_ready),
    .o_dmem_addr      (o_dmem_addr),
    .o_dmem_wen       (o_dmem_wen),
    .o_dmem_wstrb     (o_dmem_wstrb),
    .o_dmem_wdata     (o_dmem_wdata),
    .i_dmem_rsp_valid (i_dmem_rsp_valid),
    .i_dmem_rdata     (i_dmem_rdata)
  );

  function automatic e1_to_e2_s mk(memory_op_e op, memory_size_e sz, logic sgn,
                                   logic [31:0] alu, logic [31:0] rs2);
    e1_to_e2_s t;
    t               = '0;
    t.valid         = 1'b1;
    t.rd_src        = 2'd1;
    t.rd_idx        = 5'd7;
    t.rd_we         = 1'b1;
    t.csr_op        = 3'd2;
    t.csr_idx       = 12'h305;
    t.old_csr_value = 32'hCAFE_0001;
    t.alu_result    = alu;
    t.rs2           = rs2;
    t.memory_op     = op;
    t.memory_size   = sz;
    t.memory_signed = sgn;
    return t;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_e1_to_e2 = '0; i_stage_stall = 1'b0; i_stage_flush = 1'b0;
    i_dmem_req_ready = 1'b0; i_dmem_rsp_valid = 1'b0; i_dmem_rdata = '0;
    step(); step();
    checks++; if (o_e2_to_w !== '0) begin errors++; $display("FAIL reset_e2_to_w got %h exp 0", o_e2_to_w); end
    checks++; if ({o_stage_busy, o_misaligned, o_dmem_req_valid, o_dmem_wen} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {o_stage_busy, o_misaligned, o_dmem_req_valid, o_dmem_wen}); end
    checks++; if ({o_dmem_addr, o_dmem_wstrb, o_dmem_wdata} !== '0) begin
      errors++; $display("FAIL reset_bus got %h/%h/%h exp 0", o_dmem_addr, o_dmem_wstrb, o_dmem_wdata); end
    i_rst_n = 1'b1;
    step();
    $display("txn reset done");
  endtask

  task automatic test_add_bypass();
    i_e1_to_e2 = mk(MEM_OP_NOP, SIZE_WORD, 1'b0, 32'h1234, 32'h0);
    #1;
    checks++; if (o_dmem_req_valid !== 1'b0 || o_stage_busy !== 1'b0) begin
      errors++; $display("FAIL add_no_req got req=%b busy=%b exp 0/0", o_dmem_req_valid, o_stage_busy); end
    step();
    i_e1_to_e2 = '0;
    checks++; if (o_e2_to_w.valid !== 1'b1 || o_e2_to_w.alu_result !== 32'h1234) begin
      errors++; $display("FAIL add_out got v=%b alu=%h exp 1/1234", o_e2_to_w.valid, o_e2_to_w.alu_result); end
    checks++; if (o_e2_to_w.memory_rdata !== 32'h0 || o_e2_to_w.rd_idx !== 5'd7 || o_e2_to_w.csr_idx !== 12'h305
                  || o_e2_to_w.old_csr_value !== 32'hCAFE_0001 || o_e2_to_w.csr_op !== 3'd2) begin
      errors++; $display("FAIL add_fields got rdata=%h rd=%0d csr=%h old=%h op=%0d exp 0/7/305/cafe0001/2",
        o_e2_to_w.memory_rdata, o_e2_to_w.rd_idx, o_e2_to_w.csr_idx, o_e2_to_w.old_csr_value, o_e2_to_w.csr_op); end
    step();
    checks++; if (o_e2_to_w.valid !== 1'b0) begin errors++; $display("FAIL add_bubble got %b exp 0", o_e2_to_w.valid); end
    $display("txn add_bypass alu=%h", o_e2_to_w.alu_result);
  endtask

  task automatic test_load_byte();
    logic [31:0] exp_rdata;
    for (int s = 1; s >= 0; s--) begin
      exp_rdata = (s == 1) ? 32'hFFFF_FF80 : 32'h0000_0080;
      i_e1_to_e2 = mk(MEM_OP_LOAD, SIZE_BYTE, s[0], 32'h103, 32'h0);
      i_dmem_req_ready = 1'b1;
      #1;
      checks++; if (o_dmem_req_valid !== 1'b1 || o_dmem_addr !== 32'h100 || o_dmem_wstrb !== 4'b1000 || o_dmem_wen !== 1'b0) begin
        errors++; $display("FAIL lb_req got v=%b a=%h s=%b w=%b exp 1/100/1000/0",
          o_dmem_req_valid, o_dmem_addr, o_dmem_wstrb, o_dmem_wen); end
      step();
      i_dmem_req_ready = 1'b0; i_dmem_rsp_valid = 1'b1; i_dmem_rdata = 32'h80FF_0000;
      #1;
      checks++; if (o_stage_busy !== 1'b0 || o_dmem_req_valid !== 1'b0) begin
        errors++; $display("FAIL lb_rsp_busy got busy=%b req=%b exp 0/0", o_stage_busy, o_dmem_req_valid); end
      step();
      i_dmem_rsp_valid = 1'b0; i_e1_to_e2 = '0;
      checks++; if (o_e2_to_w.valid !== 1'b1 || o_e2_to_w.memory_rdata !== exp_rdata) begin
        errors++; $display("FAIL lb_data signed=%0d got v=%b d=%h exp 1/%h", s, o_e2_to_w.valid, o_e2_to_w.memory_rdata, exp_rdata); end
      $display("txn load_byte signed=%0d rdata=%h", s, o_e2_to_w.memory_rdata);
    end
  endtask

  task automatic test_store_half();
    i_e1_to_e2 = mk(MEM_OP_STORE, SIZE_HALFWORD, 1'b0, 32'h202, 32'hDEAD_BEEF);
    i_dmem_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (o_dmem_req_valid !== 1'b1 || o_stage_busy !== 1'b1 || o_dmem_addr !== 32'h200
                    || o_dmem_wdata !== 32'hBEEF_BEEF || o_dmem_wstrb !== 4'b1100 || o_dmem_wen !== 1'b1) begin
        errors++; $display("FAIL sh_hold cyc=%0d got v=%b b=%b a=%h d=%h s=%b w=%b exp 1/1/200/beefbeef/1100/1", c,
          o_dmem_req_valid, o_stage_busy, o_dmem_addr, o_dmem_wdata, o_dmem_wstrb, o_dmem_wen); end
      step();
    end
    i_dmem_req_ready = 1'b1;
    step();
    i_dmem_req_ready = 1'b0;
    #1;
    checks++; if (o_stage_busy !== 1'b1 || o_dmem_req_valid !== 1'b0) begin
      errors++; $display("FAIL sh_wait got busy=%b req=%b exp 1/0", o_stage_busy, o_dmem_req_valid); end
    step();
    i_dmem_rsp_valid = 1'b1; i_dmem_rdata = 32'h0;
    step();
    i_dmem_rsp_valid = 1'b0; i_e1_to_e2 = '0;
    checks++; if (o_e2_to_w.valid !== 1'b1 || o_e2_to_w.memory_rdata !== 32'h0 || o_e2_to_w.alu_result !== 32'h202) begin
      errors++; $display("FAIL sh_done got v=%b d=%h a=%h exp 1/0/202", o_e2_to_w.valid, o_e2_to_w.memory_rdata, o_e2_to_w.alu_result); end
    $display("txn store_half addr=%h", o_e2_to_w.alu_result);
  endtask

  task automatic test_store_byte_lanes();
    i_stage_stall = 1'b1;
    i_e1_to_e2 = mk(MEM_OP_STORE, SIZE_BYTE, 1'b0, 32'h3, 32'h1234_56A5);
    #1;
    checks++; if (o_dmem_wstrb !== 4'b1000 || o_dmem_wdata !== 32'hA5A5_A5A5 || o_dmem_req_valid !== 1'b0) begin
      errors++; $display("FAIL sb_lanes got s=%b d=%h req=%b exp 1000/a5a5a5a5/0", o_dmem_wstrb, o_dmem_wdata, o_dmem_req_valid); end
    i_e1_to_e2 = mk(MEM_OP_STORE, SIZE_WORD, 1'b0, 32'h8, 32'h1234_56A5);
    #1;
    checks++; if (o_dmem_wstrb !== 4'hF || o_dmem_wdata !== 32'h1234_56A5) begin
      errors++; $display("FAIL sw_lanes got s=%b d=%h exp 1111/123456a5", o_dmem_wstrb, o_dmem_wdata); end
    i_e1_to_e2 = '0; i_stage_stall = 1'b0;
    step();
    $display("txn store_lanes");
  endtask

  task automatic test_stall_at_response();
    i_e1_to_e2 = mk(MEM_OP_LOAD, SIZE_WORD, 1'b0, 32'h104, 32'h0);
    i_dmem_req_ready = 1'b1;
    step();
    i_dmem_req_ready = 1'b0; i_stage_stall = 1'b1; i_dmem_rsp_valid = 1'b1; i_dmem_rdata = 32'h1122_3344;
    #1;
    checks++; if (o_stage_busy !== 1'b1) begin errors++; $display("FAIL stall_rsp_busy got %b exp 1", o_stage_busy); end
    step();
    i_dmem_rsp_valid = 1'b0; i_dmem_rdata = 32'hDEAD_DEAD;
    step();
    checks++; if (o_e2_to_w.valid !== 1'b0 || o_stage_busy !== 1'b1) begin
      errors++; $display("FAIL stall_hold got v=%b busy=%b exp 0/1", o_e2_to_w.valid, o_stage_busy); end
    i_stage_stall = 1'b0;
    #1;
    checks++; if (o_stage_busy !== 1'b0) begin errors++; $display("FAIL stall_release_busy got %b exp 0", o_stage_busy); end
    step();
    i_e1_to_e2 = '0;
    checks++; if (o_e2_to_w.valid !== 1'b1 || o_e2_to_w.memory_rdata !== 32'h1122_3344 || o_e2_to_w.alu_result !== 32'h104) begin
      errors++; $display("FAIL stall_data got v=%b d=%h a=%h exp 1/11223344/104",
        o_e2_to_w.valid, o_e2_to_w.memory_rdata, o_e2_to_w.alu_result); end
    $display("txn stall_at_response rdata=%h", o_e2_to_w.memory_rdata);
  endtask

  task automatic test_flush();
    i_e1_to_e2 = mk(MEM_OP_NOP, SIZE_WORD, 1'b0, 32'h77, 32'h0);
    step();
    i_e1_to_e2 = '0; i_stage_stall = 1'b1; i_stage_flush = 1'b1;
    step();
    i_stage_stall = 1'b0; i_stage_flush = 1'b0;
    checks++; if (o_e2_to_w.valid !== 1'b0) begin errors++; $display("FAIL flush_over_stall got %b exp 0", o_e2_to_w.valid); end
    i_e1_to_e2 = mk(MEM_OP_LOAD, SIZE_WORD, 1'b0, 32'h108, 32'h0);
    i_dmem_req_ready = 1'b1;
    step();
    i_dmem_req_ready = 1'b0; i_stage_flush = 1'b1;
    #1;
    checks++; if (o_stage_busy !== 1'b1) begin errors++; $display("FAIL flush_wait_busy got %b exp 1", o_stage_busy); end
    step();
    i_stage_flush = 1'b0;
    i_e1_to_e2 = mk(MEM_OP_NOP, SIZE_WORD, 1'b0, 32'h55, 32'h0);
    checks++; if (o_e2_to_w.valid !== 1'b0 || o_stage_busy !== 1'b1 || o_dmem_req_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drain got v=%b busy=%b req=%b exp 0/1/0", o_e2_to_w.valid, o_stage_busy, o_dmem_req_valid); end
    i_dmem_rsp_valid = 1'b1; i_dmem_rdata = 32'hFFFF_FFFF;
    step();
    i_dmem_rsp_valid = 1'b0;
    checks++; if (o_e2_to_w.valid !== 1'b0 || o_stage_busy !== 1'b0) begin
      errors++; $display("FAIL flush_discard got v=%b busy=%b exp 0/0", o_e2_to_w.valid, o_stage_busy); end
    step();
    i_e1_to_e2 = '0;
    checks++; if (o_e2_to_w.valid !== 1'b1 || o_e2_to_w.alu_result !== 32'h55 || o_e2_to_w.memory_rdata !== 32'h0) begin
      errors++; $display("FAIL flush_next got v=%b a=%h d=%h exp 1/55/0", o_e2_to_w.valid, o_e2_to_w.alu_result, o_e2_to_w.memory_rdata); end
    $display("txn flush_while_waiting next_alu=%h", o_e2_to_w.alu_result);
  endtask

  task automatic test_misaligned();
    i_e1_to_e2 = mk(MEM_OP_STORE, SIZE_HALFWORD, 1'b0, 32'h201, 32'h0);
    #1;
    checks++; if (o_misaligned !== 1'b1 || o_dmem_req_valid !== 1'b0) begin
      errors++; $display("FAIL mis_half got m=%b req=%b exp 1/0", o_misaligned, o_dmem_req_valid); end
    i_e1_to_e2 = mk(MEM_OP_LOAD, SIZE_WORD, 1'b0, 32'h101, 32'h0);
    i_dmem_req_ready = 1'b1;
    #1;
    checks++; if (o_misaligned !== 1'b1 || o_dmem_req_valid !== 1'b0 || o_stage_busy !== 1'b0) begin
      errors++; $display("FAIL mis_word got m=%b req=%b busy=%b exp 1/0/0", o_misaligned, o_dmem_req_valid, o_stage_busy); end
    step();
    i_e1_to_e2 = '0; i_dmem_req_ready = 1'b0;
    #1;
    checks++; if (o_misaligned !== 1'b0 || o_e2_to_w.valid !== 1'b0 || o_e2_to_w.alu_result !== 32'h101) begin
      errors++; $display("FAIL mis_after got m=%b v=%b a=%h exp 0/0/101", o_misaligned, o_e2_to_w.valid, o_e2_to_w.alu_result); end
    $display("txn misaligned addr=%h", o_e2_to_w.alu_result);
  endtask

  task automatic test_reset_mid_access();
    i_e1_to_e2 = mk(MEM_OP_LOAD, SIZE_WORD, 1'b0, 32'h10C, 32'h0);
    i_dmem_req_ready = 1'b1;
    step();
    i_dmem_req_ready = 1'b0; i_rst_n = 1'b0; i_e1_to_e2 = '0;
    step();
    checks++; if (o_e2_to_w !== '0 || o_stage_busy !== 1'b0 || o_dmem_req_valid !== 1'b0 || o_misaligned !== 1'b0) begin
      errors++; $display("FAIL rst_mid got out=%h busy=%b req=%b exp 0/0/0", o_e2_to_w, o_stage_busy, o_dmem_req_valid); end
    i_rst_n = 1'b1;
    i_e1_to_e2 = mk(MEM_OP_NOP, SIZE_WORD, 1'b0, 32'h99, 32'h0);
    step();
    i_e1_to_e2 = '0;
    checks++; if (o_e2_to_w.valid !== 1'b1 || o_e2_to_w.alu_result !== 32'h99) begin
      errors++; $display("FAIL rst_mid_idle got v=%b a=%h exp 1/99", o_e2_to_w.valid, o_e2_to_w.alu_result); end
    $display("txn reset_mid_access");
  endtask

  initial begin
    test_reset();
    test_add_bypass();
    test_load_byte();
    test_store_half();
    test_store_byte_lanes();
    test_stall_at_response();
    test_flush();
    test_misaligned();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/letc_core_stage_e2.md
Name: letc_core_stage_e2

Overview:
- Second execute (memory) stage of the LETC Core pipeline.
- Consumes the `e1_to_e2_s` bundle from E1 and performs the load/store access on the data-memory port.
- Aligns and sign-/zero-extends load data.
- Registers an `e2_to_w_s` bundle for writeback.
- Signals busy to TGHM while a memory access is outstanding, so upstream stages hold.

Parameters:
- None. Types come from `letc_pkg` and `letc_core_pkg`.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  reset: synchronous, active-low
- i_e1_to_e2  in  e1_to_e2_s  stage input; held stable by E1 while o_stage_busy or i_stage_stall
- i_stage_stall  in  1  from TGHM: hold output register, issue no new request
- i_stage_flush  in  1  from TGHM: invalidate in-flight/registered instruction
- o_stage_busy  out  1  memory op present and not yet completed
- o_e2_to_w  out  e2_to_w_s  registered output to W
- o_misaligned  out  1  one-cycle pulse: misaligned access detected, no bus request made
- o_dmem_req_valid  out  1  request valid
- i_dmem_req_ready  in  1  request accepted when valid&&ready
- o_dmem_addr  out  32  `{alu_result[31:2],2'b00}`
- o_dmem_wen  out  1  1=store
- o_dmem_wstrb  out  4  byte enables
- o_dmem_wdata  out  32  lane-replicated store data
- i_dmem_rsp_valid  in  1  response (load data or store ack), one per accepted request
- i_dmem_rdata  in  32  load word

Behaviour:
- **Reset:** state IDLE. o_e2_to_w.valid=0, other o_e2_to_w fields 0. All other outputs 0.
- **Memory op definition:** `mem_op = i_e1_to_e2.valid && memory_op!=MEM_OP_NOP`.
- **Misalignment:** halfword with addr[0]=1, or word with addr[1:0]!=0.
- **Misaligned access:**
  - o_misaligned pulses.
  - No request is made.
  - Instruction is passed to W with valid=0.
- **Byte enables (o_dmem_wstrb):**
  - Byte: 4'b0001<<addr[1:0].
  - Halfword: 4'b0011<<addr[1:0].
  - Word: 4'hF.
  - Loads also drive wstrb. Memory may ignore it.
- **Store data (o_dmem_wdata):**
  - Byte: rs2[7:0] replicated ×4.
  - Halfword: rs2[15:0] replicated ×2.
  - Word: rs2.
- **Load extraction:**
  - Shift i_dmem_rdata right by 8*addr[1:0].
  - Take the low 8/16/32 bits.
  - Sign-extend if memory_signed, else zero-extend.
  - Stores write memory_rdata=0.
- **FSM states:**
  - IDLE:
    - o_dmem_req_valid = mem_op && !misaligned && !i_stage_stall && !i_stage_flush (combinational).
    - On accept → WAIT.
    - Non-memory valid instructions register into o_e2_to_w on the next edge if !i_stage_stall.
  - WAIT:
    - req_valid=0.
    - On i_dmem_rsp_valid: if !i_stage_stall, write o_e2_to_w (valid=1, memory_rdata extracted) → IDLE; else latch extracted data into a hold buffer → DONE.
  - DONE: when !i_stage_stall, write o_e2_to_w from the hold buffer → IDLE.
  - DRAIN: entered from WAIT on i_stage_flush; discard the response when it arrives → IDLE.
- **o_stage_busy:** 1 when (IDLE && mem_op && !misaligned && !accepted-this-cycle-with-response), in WAIT until the rsp cycle, in DONE, or in DRAIN. 0 in the cycle o_e2_to_w is written. Concretely, busy = !(next-edge completes the instruction).
- **Latency:**
  - Non-memory op: 1 cycle.
  - Memory op: request accepted at cycle N, response no earlier than N+1, o_e2_to_w valid the edge after the response.
- **Output-register behaviour:**
  - i_stage_stall holds o_e2_to_w unchanged.
  - If not stalled and nothing completes, valid is written 0 (bubble).
- **Flush:**
  - i_stage_flush writes o_e2_to_w.valid=0 (overrides stall).
  - IDLE/DONE → IDLE.
  - WAIT → DRAIN, unless rsp_valid arrives the same cycle, which goes → IDLE with the data dropped.
  - A flush in DRAIN keeps DRAIN.
- **Field passthrough:** rd_src, rd_idx, rd_we, csr_op, csr_idx, old_csr_value and alu_result pass unchanged from the input.
- **Protocol assumptions:**
  - Responses never arrive in IDLE/DONE; an assertion flags a violation.
  - Only one outstanding request at a time.
- **Reset mid-access:** returns to IDLE. Any later response is the memory side's responsibility, since it is reset together with the stage.

Test Plan:
- **Add bypass:** ALU add, alu_result=0x1234, no mem → o_e2_to_w.valid=1 one cycle later, alu_result=0x1234, memory_rdata=0, o_dmem_req_valid never 1.
- **Signed byte load:** LB at addr 0x103, rdata=0x80FF_0000 → wstrb=4'b1000, o_dmem_addr=0x100, memory_rdata=0xFFFF_FF80; with memory_signed=0 (LBU), memory_rdata=0x0000_0080.
- **Halfword store:** SH at addr 0x202, rs2=0xDEAD_BEEF → o_dmem_wen=1, wstrb=4'b1100, wdata=0xBEEF_BEEF. After rsp ack, o_e2_to_w.valid=1. Ready held low 3 cycles → busy stays 1 and req_valid held with stable addr/wdata.
- **Stall at response:** LW response arrives while i_stage_stall=1 → DONE, o_e2_to_w unchanged. Stall drops → memory_rdata = latched word, busy falls the same cycle.
- **Flush while waiting:** i_stage_flush in WAIT → o_e2_to_w.valid=0, DRAIN. The later response is discarded and the next instruction completes normally.
- **Misaligned word:** LW at 0x101 → o_misaligned=1 for one cycle, no request, o_e2_to_w.valid=0. Reset asserted in WAIT → IDLE, all outputs 0 on the next edge.
